// File: rtl/mio_arb_pkg.sv
// Shared types and constants for the two-master memory arbiter.
`timescale 1ns/1ps
package mio_arb_pkg;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } arb_state_t;

    localparam int M_CPU       = 0;
    localparam int M_DMA       = 1;
    localparam int MEM_LAT_DEF = 2;
endpackage

// File: rtl/mio_arbiter_if.sv
// Bundle of CPU, DMA and memory-side signals around the arbiter.
`timescale 1ns/1ps
interface mio_arbiter_if #(parameter int AW = 32);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] cpu_wdata;
    logic [AW-1:0] cpu_rdata;
    logic          cpu_ready;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [AW-1:0] dma_wdata;
    logic [AW-1:0] dma_rdata;
    logic          dma_ready;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [AW-1:0] mem_wdata;
    logic [AW-1:0] mem_rdata;
    logic [1:0]    grant;

    // Arbiter side.
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        output cpu_rdata, cpu_ready, dma_rdata, dma_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, grant
    );

    // Requesters plus memory model side.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        input  cpu_rdata, cpu_ready, dma_rdata, dma_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, grant
    );
endinterface

// File: rtl/mio_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the master not granted last wins.
`timescale 1ns/1ps
module rr_pick2
    import mio_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_grant
);
    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = 2'b00;
            if (i_last == 1'(M_DMA)) o_grant[M_CPU] = 1'b1;
            else                     o_grant[M_DMA] = 1'b1;
        end
    end
endmodule

// File: rtl/mio_arbiter.sv
// Two-master (CPU/DMA) arbiter for a single fixed-latency memory port.
`timescale 1ns/1ps
module mio_arbiter
    import mio_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    mio_arbiter_if.slave  bus
);
    localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

    arb_state_t    r_state;
    arb_state_t    w_state_next;
    logic [2:0]    r_cnt;
    logic          r_last;
    logic [1:0]    r_grant;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_wdata;
    logic [AW-1:0] r_cpu_rdata;
    logic [AW-1:0] r_dma_rdata;
    logic [1:0]    w_pick;
    logic          w_last_cycle;

    rr_pick2 u_pick (
        .i_req   ({bus.dma_req, bus.cpu_req}),
        .i_last  (r_last),
        .o_grant (w_pick)
    );

    assign w_last_cycle = (r_state == S_ACCESS) && (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.cpu_ready = 1'b0;
        bus.dma_ready = 1'b0;
        bus.grant     = r_grant;
        bus.cpu_rdata = r_cpu_rdata;
        bus.dma_rdata = r_dma_rdata;
        case (r_state)
            S_IDLE: begin
                if (|w_pick) w_state_next = S_ACCESS;
            end
            S_ACCESS: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = r_we;
                bus.mem_addr  = r_addr;
                bus.mem_wdata = r_wdata;
                if (w_last_cycle) w_state_next = S_DONE;
            end
            S_DONE: begin
                bus.cpu_ready = r_grant[M_CPU];
                bus.dma_ready = r_grant[M_DMA];
                w_state_next  = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Request fields are latched once in IDLE so the memory side sees stable values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_last      <= 1'(M_DMA);
            r_grant     <= 2'b00;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_pick) begin
                        r_grant <= w_pick;
                        r_cnt   <= '0;
                        r_we    <= w_pick[M_CPU] ? bus.cpu_we    : bus.dma_we;
                        r_addr  <= w_pick[M_CPU] ? bus.cpu_addr  : bus.dma_addr;
                        r_wdata <= w_pick[M_CPU] ? bus.cpu_wdata : bus.dma_wdata;
                    end
                end
                S_ACCESS: begin
                    if (w_last_cycle) begin
                        r_last <= r_grant[M_DMA];
                        if (!r_we) begin
                            if (r_grant[M_CPU]) r_cpu_rdata <= bus.mem_rdata;
                            else                r_dma_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_DONE:  r_grant <= 2'b00;
                default: r_grant <= 2'b00;
            endcase
        end
    end
endmodule
